// File: rtl/nec_ir_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : nec_ir_encoder
//  Purpose  : NEC-format infrared transmitter. A 32-bit command word is taken
//             through a start/ready handshake. It is serialised as a leader
//             (16 units mark, 8 units space), then 32 data bits LSB first
//             (1 unit mark; 1 unit space for a 0, 3 units for a 1), then a
//             1-unit stop mark. A gap of GAP_UNITS space follows before the
//             encoder reports ready again.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1   system clock
//    rst          in   1   asynchronous reset, active low (0 = reset)
//    start        in   1   send request, honoured only while ready=1
//    repeat_code  in   1   (NEC_REPEAT_EN builds only) sampled with start;
//                          1 = send the NEC repeat code instead of a frame
//    command      in  32   frame word, bit 0 transmitted first
//    ready        out  1   encoder idle, a start will be accepted
//    done         out  1   one-cycle pulse on the last cycle of the gap
//    env_out      out  1   frame envelope, 1 = mark
//    ir_out       out  1   env_out gated with the carrier
// ----------------------------------------------------------------------------
//  Build option
//    NEC_REPEAT_EN : when defined, adds the repeat_code input. The repeat
//                    code is 16 units mark, 4 units space and 1 unit mark,
//                    followed by the normal gap. When undefined, only full
//                    frames are produced.
//    The NEC name for that input is "repeat". It is a reserved word in
//    SystemVerilog, so the port is called repeat_code.
// ============================================================================
module nec_ir_encoder #(
  parameter int CLK_HZ     = 25000000,
  parameter int CARRIER_HZ = 38000,
  parameter int UNIT_HZ    = 1778,
  parameter int GAP_UNITS  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
`ifdef NEC_REPEAT_EN
  input  logic        repeat_code,
`endif
  input  logic [31:0] command,
  output logic        ready,
  output logic        done,
  output logic        env_out,
  output logic        ir_out
);

  // --------------------------------------------------------------------------
  // Derived timing constants
  // --------------------------------------------------------------------------
  localparam int c_unit_cyc  = CLK_HZ / UNIT_HZ;
  localparam int c_car_cyc   = CLK_HZ / CARRIER_HZ;
  localparam int c_car_hi    = c_car_cyc / 2;
  localparam int c_uw        = (c_unit_cyc > 1) ? $clog2(c_unit_cyc) : 1;
  localparam int c_cw        = (c_car_cyc > 1) ? $clog2(c_car_cyc) : 1;
  localparam int c_max_units = (GAP_UNITS > 16) ? GAP_UNITS : 16;
  localparam int c_dw        = $clog2(c_max_units + 1);

  localparam logic [c_uw-1:0] c_unit_last = c_uw'(c_unit_cyc - 1);
  localparam logic [c_cw-1:0] c_car_last  = c_cw'(c_car_cyc - 1);
  localparam logic [c_cw-1:0] c_car_hi_v  = c_cw'(c_car_hi);

  // State durations are stored as (units - 1). This lets them be compared
  // directly with the units-elapsed counter on the closing unit boundary.
  localparam logic [c_dw-1:0] c_d_lead_mark  = c_dw'(15);
  localparam logic [c_dw-1:0] c_d_lead_space = c_dw'(7);
  localparam logic [c_dw-1:0] c_d_rpt_space  = c_dw'(3);
  localparam logic [c_dw-1:0] c_d_one_unit   = c_dw'(0);
  localparam logic [c_dw-1:0] c_d_one_space  = c_dw'(2);
  localparam logic [c_dw-1:0] c_d_gap        = c_dw'(GAP_UNITS - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LEAD_MARK  = 3'd1,
    S_LEAD_SPACE = 3'd2,
    S_BIT_MARK   = 3'd3,
    S_BIT_SPACE  = 3'd4,
    S_STOP_MARK  = 3'd5,
    S_GAP        = 3'd6
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t            r_state;
  logic [c_uw-1:0]   r_unit;    // cycle within the current unit
  logic [c_dw-1:0]   r_ucnt;    // units elapsed in the current state
  logic [c_cw-1:0]   r_car;     // carrier phase, valid during marks
  logic [31:0]       r_shift;   // bit 0 is the bit being transmitted
  logic [4:0]        r_bit;     // index of the bit being transmitted
  logic              r_rpt;     // current transfer is a repeat code

  // --------------------------------------------------------------------------
  // Next-state signals
  // --------------------------------------------------------------------------
  state_t            w_state_nxt;
  logic [c_uw-1:0]   w_unit_nxt;
  logic [c_dw-1:0]   w_ucnt_nxt;
  logic [c_cw-1:0]   w_car_nxt;
  logic [31:0]       w_shift_nxt;
  logic [4:0]        w_bit_nxt;
  logic              w_rpt_nxt;
  logic              w_rpt_req;
  logic              w_accept;
  logic              w_unit_wrap;
  logic              w_state_end;
  logic [c_dw-1:0]   w_dur_last;
  logic              w_mark_nxt;
  logic              w_done_nxt;

`ifdef NEC_REPEAT_EN
  assign w_rpt_req = repeat_code;
`else
  assign w_rpt_req = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_accept    = start && ready;
    w_unit_wrap = (r_unit == c_unit_last);

    // Length of the current state in units, minus one.
    w_dur_last = c_d_one_unit;
    case (r_state)
      S_LEAD_MARK:  w_dur_last = c_d_lead_mark;
      S_LEAD_SPACE: w_dur_last = r_rpt ? c_d_rpt_space : c_d_lead_space;
      S_BIT_MARK:   w_dur_last = c_d_one_unit;
      S_BIT_SPACE:  w_dur_last = r_shift[0] ? c_d_one_space : c_d_one_unit;
      S_STOP_MARK:  w_dur_last = c_d_one_unit;
      S_GAP:        w_dur_last = c_d_gap;
      default:      w_dur_last = c_d_one_unit;
    endcase

    w_state_end = w_unit_wrap && (r_ucnt == w_dur_last);

    w_state_nxt = r_state;
    w_unit_nxt  = w_unit_wrap ? '0 : r_unit + 1'b1;
    w_ucnt_nxt  = w_unit_wrap ? r_ucnt + 1'b1 : r_ucnt;
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit;
    w_rpt_nxt   = r_rpt;

    if (r_state == S_IDLE) begin
      // The timing counters stay at zero while idle. Each frame therefore
      // starts on a fresh unit boundary.
      w_unit_nxt = '0;
      w_ucnt_nxt = '0;
      if (w_accept) begin
        w_state_nxt = S_LEAD_MARK;
        w_shift_nxt = command;
        w_bit_nxt   = 5'd0;
        w_rpt_nxt   = w_rpt_req;
      end
    end else if (w_state_end) begin
      w_ucnt_nxt = '0;
      case (r_state)
        S_LEAD_MARK:  w_state_nxt = S_LEAD_SPACE;
        S_LEAD_SPACE: w_state_nxt = r_rpt ? S_STOP_MARK : S_BIT_MARK;
        S_BIT_MARK:   w_state_nxt = S_BIT_SPACE;
        S_BIT_SPACE: begin
          w_shift_nxt = {1'b0, r_shift[31:1]};
          if (r_bit == 5'd31) begin
            w_state_nxt = S_STOP_MARK;
          end else begin
            w_state_nxt = S_BIT_MARK;
            w_bit_nxt   = r_bit + 1'b1;
          end
        end
        S_STOP_MARK:  w_state_nxt = S_GAP;
        S_GAP:        w_state_nxt = S_IDLE;
        default:      w_state_nxt = S_IDLE;
      endcase
    end

    w_mark_nxt = (w_state_nxt == S_LEAD_MARK) ||
                 (w_state_nxt == S_BIT_MARK)  ||
                 (w_state_nxt == S_STOP_MARK);

    // The carrier phase is held at zero through spaces. Every burst
    // therefore begins on the high half of the carrier. No two marks are
    // adjacent, so "entering a mark" is the same as "previous cycle was a
    // space".
    if (w_mark_nxt && env_out) begin
      w_car_nxt = (r_car == c_car_last) ? '0 : r_car + 1'b1;
    end else begin
      w_car_nxt = '0;
    end

    // The outputs are registered from next-state values. done therefore
    // lines up with the final GAP cycle itself, not with the IDLE cycle
    // after it.
    w_done_nxt = (w_state_nxt == S_GAP) &&
                 (w_unit_nxt == c_unit_last) &&
                 (w_ucnt_nxt == c_d_gap);
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_unit  <= '0;
      r_ucnt  <= '0;
      r_car   <= '0;
      r_shift <= '0;
      r_bit   <= 5'd0;
      r_rpt   <= 1'b0;
      ready   <= 1'b1;
      done    <= 1'b0;
      env_out <= 1'b0;
      ir_out  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_unit  <= w_unit_nxt;
      r_ucnt  <= w_ucnt_nxt;
      r_car   <= w_car_nxt;
      r_shift <= w_shift_nxt;
      r_bit   <= w_bit_nxt;
      r_rpt   <= w_rpt_nxt;
      ready   <= (w_state_nxt == S_IDLE);
      done    <= w_done_nxt;
      env_out <= w_mark_nxt;
      ir_out  <= w_mark_nxt && (w_car_nxt < c_car_hi_v);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nec_ir_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_nec_ir_encoder
//  Purpose  : Directed self-checking bench for nec_ir_encoder. The encoder is
//             scaled to 10 clocks per unit and 5 clocks per carrier period.
//             Each frame's envelope, carrier and handshake are recorded, and
//             the recording is decoded independently of the design.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nec_ir_encoder;

  localparam int CLK_HZ     = 17780;
  localparam int CARRIER_HZ = 3556;
  localparam int UNIT_HZ    = 1778;
  localparam int GAP_UNITS  = 16;
  localparam int UNIT       = 10;   // 17780 / 1778
  localparam int NMAX       = 2048;

  logic        clk     = 1'b0;
  logic        rst     = 1'b0;
  logic        start   = 1'b0;
  logic        rpt     = 1'b0;
  logic [31:0] command = 32'h0;
  logic        ready, done, env_out, ir_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Recorded outputs; index k is the k-th cycle after the accept cycle.
  logic env_t [0:NMAX-1];
  logic ir_t  [0:NMAX-1];
  logic dn_t  [0:NMAX-1];
  logic rd_t  [0:NMAX-1];

  always #5 clk = ~clk;

  nec_ir_encoder #(
    .CLK_HZ     (CLK_HZ),
    .CARRIER_HZ (CARRIER_HZ),
    .UNIT_HZ    (UNIT_HZ),
    .GAP_UNITS  (GAP_UNITS)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
`ifdef NEC_REPEAT_EN
    .repeat_code (rpt),
`endif
    .command     (command),
    .ready       (ready),
    .done        (done),
    .env_out     (env_out),
    .ir_out      (ir_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issues start with cmd and records nrec cycles after the accept.
  // hold keeps start high so that the next frame follows back-to-back.
  // busy_at > 0 issues a second start with a zero command in that cycle.
  task automatic record(input logic [31:0] cmd, input int nrec, input bit hold, input int busy_at);
    @(negedge clk);
    start   = 1'b1;
    command = cmd;
    @(posedge clk);
    for (int k = 1; k <= nrec; k++) begin
      @(negedge clk);
      env_t[k] = env_out;
      ir_t[k]  = ir_out;
      dn_t[k]  = done;
      rd_t[k]  = ready;
      start    = hold;
      if (k == busy_at) begin
        start   = 1'b1;
        command = 32'h0;
      end
    end
    start = 1'b0;
  endtask

  // Decodes a recorded frame and checks it against the NEC timing.
  task automatic analyse(input string tag, input logic [31:0] exp_cmd);
    int          exp_done;
    int          runs[$];
    int          len;
    logic        cur;
    logic [31:0] dec;
    int          bad;
    int          car_err;
    int          ph;
    int          n_done;
    int          done_at;
    logic        exp_ir;
    exp_done = UNIT * (89 + 2 * $countones(exp_cmd) + GAP_UNITS);
    chk({tag, "_env_first"}, 32'(env_t[1]), 32'd1);
    cur = env_t[1];
    len = 0;
    for (int k = 1; k <= exp_done; k++) begin
      if (env_t[k] === cur) begin
        len++;
      end else begin
        runs.push_back(len);
        cur = env_t[k];
        len = 1;
      end
    end
    runs.push_back(len);
    chk({tag, "_runs"}, 32'(runs.size()), 32'd68);
    if (runs.size() == 68) begin
      chk({tag, "_lead_mark"}, 32'(runs[0]), 32'd160);
      chk({tag, "_lead_space"}, 32'(runs[1]), 32'd80);
      dec = 32'h0;
      bad = 0;
      for (int i = 0; i < 32; i++) begin
        if (runs[2 + 2 * i] != UNIT) bad++;
        if (runs[3 + 2 * i] == 3 * UNIT) dec[i] = 1'b1;
        else if (runs[3 + 2 * i] != UNIT) bad++;
      end
      chk({tag, "_bit_timing"}, 32'(bad), 32'd0);
      chk({tag, "_data"}, dec, exp_cmd);
      chk({tag, "_stop_mark"}, 32'(runs[66]), 32'd10);
      chk({tag, "_gap"}, 32'(runs[67]), 32'd160);
    end
    car_err = 0;
    ph = 0;
    for (int k = 1; k <= exp_done; k++) begin
      if (env_t[k] === 1'b1) begin
        if (k == 1 || env_t[k-1] !== 1'b1) ph = 0;
        exp_ir = ((ph % 5) < 2);
        if (ir_t[k] !== exp_ir) car_err++;
        ph++;
      end else if (ir_t[k] !== 1'b0) begin
        car_err++;
      end
    end
    chk({tag, "_carrier"}, 32'(car_err), 32'd0);
    n_done  = 0;
    done_at = 0;
    for (int k = 1; k <= exp_done + 1; k++) begin
      if (dn_t[k] === 1'b1) begin
        n_done++;
        done_at = k;
      end
    end
    chk({tag, "_done_count"}, 32'(n_done), 32'd1);
    chk({tag, "_done_at"}, 32'(done_at), 32'(exp_done));
    chk({tag, "_ready_in_gap"}, 32'(rd_t[exp_done]), 32'd0);
    chk({tag, "_ready_after"}, 32'(rd_t[exp_done + 1]), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_high;
    bit seen;

    // Reset held with start toggling.
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start   = ~start;
      command = $urandom;
      @(posedge clk);
      #1;
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_env", 32'(env_out), 32'd0);
      chk("rst_ir", 32'(ir_out), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
    end
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(ready), 32'd1);

    // Reference frame.
    record(32'hFB04_0707, 1335, 1'b0, 0);
    analyse("f1", 32'hFB04_0707);

    // A second start 200 cycles into the frame must be ignored.
    record(32'hFB04_0707, 1335, 1'b0, 200);
    analyse("busy", 32'hFB04_0707);

    // Boundary data patterns.
    record(32'h0000_0000, 1055, 1'b0, 0);
    analyse("zeros", 32'h0000_0000);
    record(32'hFFFF_FFFF, 1695, 1'b0, 0);
    analyse("ones", 32'hFFFF_FFFF);

    // Back-to-back: the second start is accepted in the ready cycle, which
    // follows the 160-cycle gap. The next leader therefore starts in cycle
    // 1332.
    record(32'hFB04_0707, 1345, 1'b1, 0);
    analyse("b2b", 32'hFB04_0707);
    first_high = 0;
    for (int k = 1171; k <= 1345; k++) begin
      if (first_high == 0 && env_t[k] === 1'b1) first_high = k;
    end
    chk("b2b_next_lead", 32'(first_high), 32'd1332);
    chk("b2b_lead_on", 32'(env_t[1345]), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 1500 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    chk("b2b_second_done", 32'(seen), 32'd1);
    @(negedge clk);
    chk("b2b_idle", 32'(ready), 32'd1);

    // Reset asserted in the BIT_SPACE of bit 10, which lasts cycles 551..580.
    @(negedge clk);
    start   = 1'b1;
    command = 32'hFB04_0707;
    @(posedge clk);
    for (int k = 1; k <= 560; k++) begin
      @(negedge clk);
      env_t[k] = env_out;
      start    = 1'b0;
    end
    chk("mid_bit10_mark", 32'(env_t[545]), 32'd1);
    chk("mid_bit10_space", 32'(env_t[555]), 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_env", 32'(env_out), 32'd0);
    chk("mid_rst_ready", 32'(ready), 32'd1);
    chk("mid_rst_ir", 32'(ir_out), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rel_ready", 32'(ready), 32'd1);
    chk("mid_rel_env", 32'(env_out), 32'd0);
    record(32'h1234_5678, 1335, 1'b0, 0);
    analyse("after_rst", 32'h1234_5678);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
